// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state
// encodings and default operand/counter widths.
package shift_add_multiplier_pkg;

    localparam int unsigned N_DEF  = 8;
    localparam int unsigned CW_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/counter.sv
// Parameterised loadable down-counter; co_c flags the terminal count (value 1),
// i.e. the next enabled step finishes the run.
module counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic         co_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority over the decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = d_i;
        end else if (en_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign co_c = (cnt_q == W'(1));

endmodule

// File: rtl/shift_add_controller.sv
// Multiplier sequencer: Idle/Load/Add/Shift/Done FSM plus the iteration counter.
// All strobes are registered from the next state so they line up with state_q.
module shift_add_controller
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic q0_i,
    output logic ld_regs_o,
    output logic add_en_o,
    output logic add_m_c,
    output logic shr_o,
    output logic ready_o,
    output logic done_o
);

    state_e state_q;
    state_e state_d;
    logic   cnt_term_c;

    counter #(
        .W(CW)
    ) u_iter_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ld_regs_o),
        .en_i   (shr_o),
        .d_i    (CW'(N)),
        .co_c   (cnt_term_c)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_ADD;
            ST_ADD:   state_d = ST_SHIFT;
            ST_SHIFT: state_d = cnt_term_c ? ST_DONE : ST_ADD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ready_o   <= 1'b1;
            done_o    <= 1'b0;
            ld_regs_o <= 1'b0;
            add_en_o  <= 1'b0;
            shr_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_o   <= (state_d == ST_IDLE);
            done_o    <= (state_d == ST_DONE);
            ld_regs_o <= (state_d == ST_LOAD);
            add_en_o  <= (state_d == ST_ADD);
            shr_o     <= (state_d == ST_SHIFT);
        end
    end

    // The add always happens; Q[0] only picks M or zero as the addend
    assign add_m_c = add_en_o & q0_i;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one add and one shift per
// multiplier bit, full 2N-bit product in {A,Q}.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
);

    logic [N-1:0] m_q, m_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] q_q, q_d;
    logic         c_q, c_d;
    logic [N:0]   sum_c;
    logic         ld_regs;
    logic         add_en;
    logic         add_m_c;
    logic         shr;

    shift_add_controller #(
        .N  (N),
        .CW (CW)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst),
        .start_i   (start),
        .q0_i      (q_q[0]),
        .ld_regs_o (ld_regs),
        .add_en_o  (add_en),
        .add_m_c   (add_m_c),
        .shr_o     (shr),
        .ready_o   (ready),
        .done_o    (done)
    );

    assign sum_c = {1'b0, a_q} + {1'b0, (add_m_c ? m_q : N'(0))};

    always_comb begin
        m_d = m_q;
        a_d = a_q;
        q_d = q_q;
        c_d = c_q;
        if (ld_regs) begin
            m_d = multiplicand;
            q_d = multiplier;
            a_d = '0;
            c_d = 1'b0;
        end else if (add_en) begin
            {c_d, a_d} = sum_c;
        end else if (shr) begin
            // {C,A,Q} shifted right by one with zero fill
            c_d = 1'b0;
            a_d = {c_q, a_q[N-1:1]};
            q_d = {a_q[0], q_q[N-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q <= '0;
            a_q <= '0;
            q_q <= '0;
            c_q <= 1'b0;
        end else begin
            m_q <= m_d;
            a_q <= a_d;
            q_q <= q_d;
            c_q <= c_d;
        end
    end

    assign product = {a_q, q_q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: table vectors, corner-case
// sequences and a random sweep, with products checked through a scoreboard.
module tb_shift_add_multiplier;

    localparam int unsigned N   = 8;
    localparam int unsigned LAT = 2 * N + 2;
    localparam int unsigned PER = 2 * N + 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [7:0]   multiplicand;
    logic [7:0]   multiplier;
    logic         ready;
    logic         done;
    logic [15:0]  product;

    shift_add_multiplier #(.N(8), .CW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    int          checks;
    int          passed;
    int          cyc;
    int          done_cnt;
    logic        prev_done;
    logic [15:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: record accepted starts, then sample outputs after the edge
    task automatic tick();
        logic [15:0] e;
        logic [15:0] got;
        if (start && ready && rst) begin
            e = 16'(multiplicand) * 16'(multiplier);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            check("done_one_cycle", 32'(prev_done), 0);
            check("ready_low_in_done", 32'(ready), 0);
            check("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("sb_product", 32'(product), 32'(got));
            end
        end
        prev_done = done;
    endtask

    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          output logic [15:0] prod, output int lat);
        int guard;
        guard = 0;
        while (!ready && guard < 60) begin
            tick();
            guard++;
        end
        check("ready_wait", 32'(ready), 1);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
        prod = product;
    endtask

    vec_t        vecs[8];
    logic [15:0] prod;
    int          lat;
    int          d0;
    int          guard;
    int          prev_dc;
    int          hold_dones;
    logic        prev_ready;
    logic [7:0]  rm;
    logic [7:0]  rq;

    initial begin
        checks       = 0;
        passed       = 0;
        cyc          = 0;
        done_cnt     = 0;
        prev_done    = 1'b0;
        rst          = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'd0};
        vecs[3] = '{8'd200, 8'd0,   16'd0};
        vecs[4] = '{8'd1,   8'd1,   16'd1};
        vecs[5] = '{8'd128, 8'd2,   16'd256};
        vecs[6] = '{8'd255, 8'd1,   16'd255};
        vecs[7] = '{8'd17,  8'd15,  16'd255};

        #12;
        check("rst_ready", 32'(ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_product", 32'(product), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].m, vecs[i].q, prod, lat);
            check("vec_latency", 32'(lat + 1), 32'(LAT));
            check("vec_product", 32'(prod), 32'(vecs[i].exp));
            tick();
            check("vec_ready_after", 32'(ready), 1);
        end

        // Operand bus and start change mid-operation
        multiplicand = 8'd6;
        multiplier   = 8'd9;
        start        = 1'b1;
        d0           = done_cnt;
        tick();
        start = 1'b0;
        repeat (3) tick();
        multiplicand = 8'd7;
        multiplier   = 8'd7;
        start        = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        guard = 0;
        while (!done && guard < 60) begin
            tick();
            guard++;
        end
        check("midop_product", 32'(product), 54);
        repeat (25) tick();
        check("midop_done_count", 32'(done_cnt - d0), 1);

        // start held high continuously with constant operands
        guard = 0;
        while (!ready && guard < 60) begin
            tick();
            guard++;
        end
        multiplicand = 8'd3;
        multiplier   = 8'd5;
        start        = 1'b1;
        prev_dc      = -1;
        hold_dones   = 0;
        prev_ready   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) begin
                hold_dones++;
                check("hold_product", 32'(product), 15);
                if (prev_dc >= 0) check("hold_period", 32'(cyc - prev_dc), 32'(PER));
                prev_dc = cyc;
            end
            if (ready) check("hold_ready_single", 32'(prev_ready), 0);
            prev_ready = ready;
        end
        start = 1'b0;
        check("hold_pulses", 32'(hold_dones), 3);
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            tick();
            guard++;
        end
        check("hold_drain", 32'(sb.size()), 0);

        // Asynchronous reset in the middle of an operation
        guard = 0;
        while (!ready && guard < 60) begin
            tick();
            guard++;
        end
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        #2 rst = 1'b0;
        #1;
        check("arst_product", 32'(product), 0);
        check("arst_ready", 32'(ready), 1);
        check("arst_done", 32'(done), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_release_ready", 32'(ready), 1);
        d0 = done_cnt;
        repeat (25) tick();
        check("arst_no_done", 32'(done_cnt - d0), 0);
        run_op(8'd100, 8'd100, prod, lat);
        check("arst_next_product", 32'(prod), 10000);
        check("arst_next_latency", 32'(lat + 1), 32'(LAT));

        // Random sweep against the arithmetic reference
        for (int i = 0; i < 500; i++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            run_op(rm, rq, prod, lat);
            check("rand_product", 32'(prod), 32'(16'(rm) * 16'(rq)));
            check("rand_latency", 32'(lat + 1), 32'(LAT));
        end
        tick();
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
